uart_frame_receiver: RTL and testbench



---
 rtl/uart_frame_receiver.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_frame_receiver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver: UART byte receiver that tags each byte with its index
// inside a panel frame and hands it to the memory controller over a level/ack
// handshake. Handles glitches, framing errors, overruns and idle-gap resync.
module uart_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT     = 434,
  parameter int unsigned FRAME_BYTES      = 48,
  parameter int unsigned IDLE_RESYNC_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       memory_access_performed,
  output logic [7:0] uart_op_buffer,
  output logic       d_rdy_flag,
  output logic [6:0] dataPointer,
  output logic       frame_done,
  output logic       framing_err,
  output logic       overrun
);

  localparam int unsigned TMR_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W       = 7;
  localparam int unsigned IDLE_CYCLES = IDLE_RESYNC_BITS * CLKS_PER_BIT;
  localparam int unsigned IDLE_W      = $clog2(IDLE_CYCLES + 1);

  localparam logic [TMR_W-1:0]  HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0]  BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t state;
  state_t state_n;

  logic              rx_meta;
  logic              rxs;
  logic [TMR_W-1:0]  tmr;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDLE_W-1:0] idle_cnt;

  logic tmr_clr_c;
  logic shift_c;
  logic byte_done_c;
  logic frm_err_c;
  logic accept_c;
  logic drop_c;
  logic resync_c;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_n     = state;
    tmr_clr_c   = 1'b0;
    shift_c     = 1'b0;
    byte_done_c = 1'b0;
    frm_err_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_clr_c = 1'b1;
        if (!rxs) begin
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tmr == HALF_LAST) begin
          tmr_clr_c = 1'b1;
          // Line back high at mid-start means it was a glitch.
          state_n   = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tmr == BIT_LAST) begin
          tmr_clr_c = 1'b1;
          shift_c   = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_n = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tmr == BIT_LAST) begin
          tmr_clr_c = 1'b1;
          if (rxs) begin
            byte_done_c = 1'b1;
            state_n     = ST_IDLE;
          end else begin
            frm_err_c = 1'b1;
            state_n   = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) must not be decoded as 0x00 bytes.
        tmr_clr_c = 1'b1;
        if (rxs) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Bit timer: free-runs within a bit, cleared at each sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (tmr_clr_c) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  // Data bit counter, only meaningful inside DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state != ST_DATA) begin
      bit_cnt <= '0;
    end else if (shift_c) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_c) begin
      shreg <= {rxs, shreg[7:1]};
    end
  end

  assign accept_c = byte_done_c && (!d_rdy_flag || memory_access_performed);
  assign drop_c   = byte_done_c && d_rdy_flag && !memory_access_performed;
  assign resync_c = (idle_cnt == IDLE_SAT) && (wr_idx != '0);

  // Idle-gap counter: counts high-line cycles in IDLE and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state == ST_IDLE) && rxs) begin
      if (idle_cnt != IDLE_SAT) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  // Frame write index: advances per accepted byte, zeroed by a long idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
    end else if (accept_c) begin
      wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + IDX_W'(1);
    end else if (resync_c) begin
      wr_idx <= '0;
    end
  end

  // Handshake outputs: byte, index and valid flag held until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_op_buffer <= '0;
      dataPointer    <= '0;
      d_rdy_flag     <= 1'b0;
    end else if (accept_c) begin
      uart_op_buffer <= shreg;
      dataPointer    <= wr_idx;
      d_rdy_flag     <= 1'b1;
    end else if (memory_access_performed) begin
      d_rdy_flag     <= 1'b0;
    end
  end

  // Status pulses and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_done  <= accept_c && (wr_idx == IDX_LAST);
      framing_err <= frm_err_c;
      if (drop_c) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Scoreboard bench for uart_frame_receiver: stimulus pushes expected bytes,
// a negedge monitor pops and compares on each rising d_rdy_flag.
module tb_uart_frame_receiver;

  localparam int unsigned C = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [6:0] idx;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] uart_op_buffer;
  logic       d_rdy_flag;
  logic [6:0] dataPointer;
  logic       frame_done;
  logic       framing_err;
  logic       overrun;

  int   vectors = 0;
  int   errors  = 0;
  int   fe_pulses = 0;
  logic d_rdy_q = 1'b0;
  exp_t exp_q[$];

  uart_frame_receiver #(
    .CLKS_PER_BIT    (C),
    .FRAME_BYTES     (4),
    .IDLE_RESYNC_BITS(20)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rx                     (rx),
    .memory_access_performed(ack),
    .uart_op_buffer         (uart_op_buffer),
    .d_rdy_flag             (d_rdy_flag),
    .dataPointer            (dataPointer),
    .frame_done             (frame_done),
    .framing_err            (framing_err),
    .overrun                (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [6:0] idx, input logic fd);
    exp_t e;
    e.data = d;
    e.idx  = idx;
    e.fd   = fd;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(C);
    end
    rx = stop_bit;
    tick(C);
    rx = 1'b1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(2);
  endtask

  // Monitor: a new byte is presented whenever d_rdy_flag rises.
  always @(negedge clk) begin
    exp_t e;
    if (d_rdy_flag && !d_rdy_q) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_byte: got data %0h idx %0d, none expected", uart_op_buffer, dataPointer);
      end else begin
        e = exp_q.pop_front();
        chk("mon_data", uart_op_buffer, e.data);
        chk("mon_idx", dataPointer, e.idx);
        chk("mon_frame_done", frame_done, e.fd);
      end
    end else if (frame_done) begin
      vectors++;
      errors++;
      $display("FAIL stray_frame_done: got 1 expected 0 (idx %0d)", dataPointer);
    end
    if (framing_err) fe_pulses++;
    d_rdy_q = d_rdy_flag;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rst_d_rdy", d_rdy_flag, 0);
    chk("rst_buffer", uart_op_buffer, 8'h00);
    chk("rst_ptr", dataPointer, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_framing_err", framing_err, 0);
    chk("rst_overrun", overrun, 0);

    // Single byte, held until acked
    expect_byte(8'hA5, 7'd0, 1'b0);
    send_byte(8'hA5, 1'b1);
    tick(20);
    chk("t1_held_flag", d_rdy_flag, 1);
    chk("t1_held_data", uart_op_buffer, 8'hA5);
    chk("t1_held_ptr", dataPointer, 0);
    chk("t1_overrun", overrun, 0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t1_flag_clr", d_rdy_flag, 0);
    tick(1);

    // Full frames with ack per byte
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      expect_byte(8'(i), 7'((i - 1) % 4), (i == 4) || (i == 8));
      send_byte(8'(i), 1'b1);
      do_ack();
    end

    // Overrun
    do_reset();
    expect_byte(8'h11, 7'd0, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(2);
    chk("t3_overrun", overrun, 1);
    chk("t3_data_kept", uart_op_buffer, 8'h11);
    chk("t3_ptr_kept", dataPointer, 0);
    chk("t3_flag", d_rdy_flag, 1);
    do_ack();
    expect_byte(8'h33, 7'd1, 1'b0);
    send_byte(8'h33, 1'b1);
    do_ack();
    chk("t3_overrun_sticky", overrun, 1);

    // Framing error followed by a long break
    do_reset();
    send_byte(8'h55, 1'b0);
    rx = 1'b0;
    tick(40 * C);
    chk("t4_no_flag", d_rdy_flag, 0);
    chk("t4_fe_pulses", fe_pulses, 1);
    rx = 1'b1;
    tick(C);
    expect_byte(8'h66, 7'd0, 1'b0);
    send_byte(8'h66, 1'b1);
    do_ack();

    // Idle resync: long gap restarts the frame
    do_reset();
    expect_byte(8'hA1, 7'd0, 1'b0);
    send_byte(8'hA1, 1'b1);
    do_ack();
    expect_byte(8'hA2, 7'd1, 1'b0);
    send_byte(8'hA2, 1'b1);
    do_ack();
    tick(25 * C);
    expect_byte(8'h77, 7'd0, 1'b0);
    send_byte(8'h77, 1'b1);
    do_ack();

    // Short gap keeps the frame position
    do_reset();
    expect_byte(8'hB1, 7'd0, 1'b0);
    send_byte(8'hB1, 1'b1);
    do_ack();
    expect_byte(8'hB2, 7'd1, 1'b0);
    send_byte(8'hB2, 1'b1);
    do_ack();
    tick(10 * C);
    expect_byte(8'h77, 7'd2, 1'b0);
    send_byte(8'h77, 1'b1);
    do_ack();

    // Glitch produces nothing
    do_reset();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(12 * C);
    chk("t6_glitch_flag", d_rdy_flag, 0);

    // Reset during data bit 4
    expect_byte(8'h3C, 7'd0, 1'b0);
    send_byte(8'h3C, 1'b1);
    do_ack();
    expect_byte(8'hC3, 7'd1, 1'b0);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h5A, 1'b1);
    tick(2);
    chk("t6_pre_overrun", overrun, 1);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick(C);
    end
    rx = 1'b1;
    tick(C / 2);
    rst_n = 1'b0;
    tick(3);
    chk("t6_rst_flag", d_rdy_flag, 0);
    chk("t6_rst_buffer", uart_op_buffer, 8'h00);
    chk("t6_rst_ptr", dataPointer, 0);
    chk("t6_rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(C);
    chk("t6_post_flag", d_rdy_flag, 0);
    expect_byte(8'h99, 7'd0, 1'b0);
    send_byte(8'h99, 1'b1);
    do_ack();

    tick(20);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_fe_pulses", fe_pulses, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
